// File: rtl/shared_net_arbiter_if.sv
// rtl/shared_net_arbiter_if.sv - requester/arbiter bundle for the shared result net
interface shared_net_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 8
);
    localparam int OW = $clog2(N_REQ);

    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] din;
    logic [N_REQ-1:0]    gnt;
    logic [OW-1:0]       owner;
    logic [DW-1:0]       bus_out;
    logic                bus_valid;
    logic                busy;

    modport master (
        output req, din,
        input  gnt, owner, bus_out, bus_valid, busy
    );

    modport slave (
        input  req, din,
        output gnt, owner, bus_out, bus_valid, busy
    );
endinterface

// File: rtl/shared_net_arbiter.sv
// rtl/shared_net_arbiter.sv - round-robin owner of a single shared net with one dead cycle between owners
module shared_net_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DW       = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    shared_net_arbiter_if.slave bus
);
    localparam int OW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [OW-1:0] LAST_IDX  = OW'(N_REQ - 1);
    localparam logic [HW-1:0] LAST_BEAT = HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [OW-1:0]    r_owner;
    logic [OW-1:0]    r_rr_ptr;
    logic [HW-1:0]    r_hold_cnt;
    logic [DW-1:0]    r_bus_out;
    logic             r_bus_valid;

    state_t           w_state_nxt;
    logic [N_REQ-1:0] w_gnt_nxt;
    logic [OW-1:0]    w_owner_nxt;
    logic [OW-1:0]    w_rr_ptr_nxt;
    logic [HW-1:0]    w_hold_cnt_nxt;
    logic [DW-1:0]    w_bus_out_nxt;
    logic             w_bus_valid_nxt;

    logic [OW:0]      w_arb;
    logic             w_found;
    logic [OW-1:0]    w_win;
    logic [N_REQ-1:0] w_win_onehot;
    logic             w_req_owner;
    logic [DW-1:0]    w_din_owner;
    logic [OW-1:0]    w_owner_inc;

    // Search upward from ptr with an explicit wrap so non-power-of-two N_REQ works.
    function automatic logic [OW:0] arbitrate(input logic [N_REQ-1:0] r, input logic [OW-1:0] ptr);
        logic          found;
        logic [OW-1:0] win;
        logic [OW-1:0] sel;
        int            idx;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            sel = OW'(idx);
            if (!found && r[sel]) begin
                found = 1'b1;
                win   = sel;
            end
        end
        return {found, win};
    endfunction

    assign w_arb        = arbitrate(bus.req, r_rr_ptr);
    assign w_found      = w_arb[OW];
    assign w_win        = w_arb[OW-1:0];
    assign w_win_onehot = N_REQ'(1) << w_win;
    assign w_req_owner  = bus.req[r_owner];
    assign w_din_owner  = bus.din[r_owner*DW +: DW];
    assign w_owner_inc  = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;

    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_owner_nxt     = r_owner;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_bus_out_nxt   = r_bus_out;
        w_bus_valid_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                w_gnt_nxt = '0;
                if (w_found) begin
                    w_state_nxt    = OWN;
                    w_gnt_nxt      = w_win_onehot;
                    w_owner_nxt    = w_win;
                    w_hold_cnt_nxt = '0;
                end
            end
            OWN: begin
                if (w_req_owner) begin
                    w_bus_out_nxt   = w_din_owner;
                    w_bus_valid_nxt = 1'b1;
                    if (r_hold_cnt == LAST_BEAT) begin
                        w_state_nxt    = GAP;
                        w_gnt_nxt      = '0;
                        w_rr_ptr_nxt   = w_owner_inc;
                        w_hold_cnt_nxt = '0;
                    end else begin
                        w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                    end
                end else begin
                    // Release beats the hold limit: no beat on this edge.
                    w_state_nxt    = GAP;
                    w_gnt_nxt      = '0;
                    w_rr_ptr_nxt   = w_owner_inc;
                    w_hold_cnt_nxt = '0;
                end
            end
            GAP: begin
                if (w_found) begin
                    w_state_nxt    = OWN;
                    w_gnt_nxt      = w_win_onehot;
                    w_owner_nxt    = w_win;
                    w_hold_cnt_nxt = '0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_hold_cnt  <= '0;
            r_bus_out   <= '0;
            r_bus_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_owner     <= w_owner_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_bus_out   <= w_bus_out_nxt;
            r_bus_valid <= w_bus_valid_nxt;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.owner     = r_owner;
    assign bus.bus_out   = r_bus_out;
    assign bus.bus_valid = r_bus_valid;
    assign bus.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_shared_net_arbiter.sv
// tb/tb_shared_net_arbiter.sv - directed bench for shared_net_arbiter (N_REQ=4 and N_REQ=3 instances)
module tb_shared_net_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    shared_net_arbiter_if #(.N_REQ(4), .DW(8)) bus4 ();
    shared_net_arbiter_if #(.N_REQ(3), .DW(8)) bus3 ();

    shared_net_arbiter #(.N_REQ(4), .DW(8), .MAX_HOLD(8)) u4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    shared_net_arbiter #(.N_REQ(3), .DW(8), .MAX_HOLD(2)) u3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int t;
        int phase;
        int grp;
        int exp_own;

        bus4.req = '0;
        bus4.din = '0;
        bus3.req = '0;
        bus3.din = '0;

        // reset without a clock edge
        #1;
        rst_n = 1'b0;
        #2;
        chk("rst_gnt", bus4.gnt, 0);
        chk("rst_owner", bus4.owner, 0);
        chk("rst_bus_out", bus4.bus_out, 0);
        chk("rst_valid", bus4.bus_valid, 0);
        chk("rst_busy", bus4.busy, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("idle_gnt", bus4.gnt, 0);

        // single burst on requester 2
        bus4.req = 4'b0100;
        step();
        chk("burst_gnt", bus4.gnt, 4'b0100);
        chk("burst_owner", bus4.owner, 2);
        chk("burst_busy", bus4.busy, 1);
        chk("burst_v0", bus4.bus_valid, 0);
        bus4.din[16 +: 8] = 8'h11;
        step();
        chk("burst_v1", bus4.bus_valid, 1);
        chk("burst_d1", bus4.bus_out, 8'h11);
        bus4.din[16 +: 8] = 8'h22;
        step();
        chk("burst_d2", bus4.bus_out, 8'h22);
        bus4.din[16 +: 8] = 8'h33;
        step();
        chk("burst_d3", bus4.bus_out, 8'h33);
        chk("burst_v3", bus4.bus_valid, 1);
        bus4.req = 4'b0000;
        step();
        chk("burst_gap_gnt", bus4.gnt, 0);
        chk("burst_gap_valid", bus4.bus_valid, 0);
        chk("burst_gap_busy", bus4.busy, 1);
        chk("burst_hold_out", bus4.bus_out, 8'h33);
        step();
        chk("burst_idle_busy", bus4.busy, 0);
        chk("burst_idle_gnt", bus4.gnt, 0);

        // N_REQ=3 wrap: owner 2 pre-empted while all request
        bus3.din = {8'hC2, 8'hC1, 8'hC0};
        bus3.req = 3'b100;
        step();
        chk("wrap_gnt2", bus3.gnt, 3'b100);
        chk("wrap_owner2", bus3.owner, 2);
        bus3.req = 3'b111;
        step();
        chk("wrap_beat1", bus3.bus_out, 8'hC2);
        step();
        chk("wrap_gap_gnt", bus3.gnt, 0);
        chk("wrap_gap_valid", bus3.bus_valid, 1);
        step();
        chk("wrap_next_gnt", bus3.gnt, 3'b001);
        chk("wrap_next_owner", bus3.owner, 0);
        chk("wrap_next_valid", bus3.bus_valid, 0);
        bus3.req = '0;

        // fair ordering
        do_reset();
        bus4.din = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        bus4.req = 4'b0101;
        step();
        chk("fair_first_gnt", bus4.gnt, 4'b0001);
        chk("fair_first_owner", bus4.owner, 0);
        bus4.req = 4'b0100;
        step();
        chk("fair_gap_gnt", bus4.gnt, 0);
        bus4.req = 4'b0101;
        step();
        chk("fair_second_gnt", bus4.gnt, 4'b0100);
        chk("fair_second_owner", bus4.owner, 2);
        bus4.din[16 +: 8] = 8'h5A;
        step();
        chk("fair_beat", bus4.bus_out, 8'h5A);
        chk("fair_beat_valid", bus4.bus_valid, 1);

        // asynchronous reset mid-grant
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", bus4.gnt, 0);
        chk("mid_rst_valid", bus4.bus_valid, 0);
        chk("mid_rst_busy", bus4.busy, 0);
        chk("mid_rst_owner", bus4.owner, 0);
        chk("mid_rst_bus_out", bus4.bus_out, 0);
        #1;
        rst_n = 1'b1;
        bus4.req = 4'b1111;
        step();
        chk("mid_rst_restart_gnt", bus4.gnt, 4'b0001);

        // saturated rotation: 9-cycle period per owner
        do_reset();
        bus4.din = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        bus4.req = 4'b1111;
        for (t = 1; t <= 37; t++) begin
            step();
            phase   = (t - 1) % 9;
            grp     = (t - 1) / 9;
            exp_own = grp % 4;
            chk($sformatf("sat_gnt_t%0d", t), bus4.gnt, (phase < 8) ? (32'd1 << exp_own) : 32'd0);
            chk($sformatf("sat_owner_t%0d", t), bus4.owner, exp_own);
            chk($sformatf("sat_valid_t%0d", t), bus4.bus_valid, (phase >= 1) ? 1 : 0);
            if (phase >= 1) begin
                chk($sformatf("sat_data_t%0d", t), bus4.bus_out, 8'hA0 + exp_own);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
